peripheral_crc_7: RTL and testbench

PERIPHERAL_CRC_7 -- requirements
Module: peripheral_crc_7

---
 rtl/peripheral_crc_7.sv | 87 ++++++++
 tb/tb_peripheral_crc_7.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/peripheral_crc_7.sv
// Register-mapped SD-style CRC7 engine: a 40-bit command/argument message is
// shifted MSB first through x^7+x^3+1, one bit per clock.
module peripheral_crc_7 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [39:0] msg, shift;
    logic [6:0]  crc, crc_nxt;
    logic [5:0]  cnt;
    logic        done, busy;
    logic        wr_en, start, fb;

    assign busy  = (state == BUSY);
    assign wr_en = cs && wr;
    assign start = wr_en && (addr == 4'h4) && d_in[0] && (state == IDLE);

    assign fb      = shift[39] ^ crc[6];
    assign crc_nxt = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == 6'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Message registers are frozen while busy; the engine works on its own shift copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg   <= '0;
            shift <= '0;
            crc   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            if (wr_en && state == IDLE) begin
                case (addr)
                    4'h0:    msg[39:32] <= d_in[7:0];
                    4'h2:    msg[31:16] <= d_in;
                    4'hA:    msg[15:0]  <= d_in;
                    default: ;
                endcase
            end
            if (start) begin
                shift <= msg;
                crc   <= '0;
                cnt   <= 6'd39;
                done  <= 1'b0;
            end else if (state == BUSY) begin
                shift <= {shift[38:0], 1'b0};
                crc   <= crc_nxt;
                if (cnt == 6'd0) done <= 1'b1;
                else             cnt  <= cnt - 6'd1;
            end
        end
    end

    always_comb begin
        d_out = 16'h0000;
        if (cs && rd) begin
            case (addr)
                4'h6:    d_out = {14'h0, busy, done};
                4'h8:    d_out = {9'h0, crc};
                4'hC:    d_out = {8'h0, crc, 1'b1};
                default: d_out = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_crc_7.sv
// Directed bench for peripheral_crc_7 using known SD command CRCs.
module tb_peripheral_crc_7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;

    int total = 0;
    int bad   = 0;

    peripheral_crc_7 dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs),
        .addr(addr), .rd(rd), .wr(wr), .d_out(d_out)
    );

    always #5 clk = ~clk;

    // Write spans exactly one rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; d_in = '0; addr = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        v = d_out;
        cs = 1'b0; rd = 1'b0; addr = '0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_msg(input logic [39:0] m);
        bus_write(4'h0, {8'h00, m[39:32]});
        bus_write(4'h2, m[31:16]);
        bus_write(4'hA, m[15:0]);
    endtask

    task automatic test_reset;
        logic [15:0] v;
        rst = 1'b0;
        #3;
        bus_read(4'h6, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", v, 16'h0000); end
        bus_read(4'h8, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL reset_crc got=%h exp=%h", v, 16'h0000); end
        bus_read(4'hC, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL reset_sdcrc got=%h exp=%h", v, 16'h0001); end
        edges(2);
        rst = 1'b1;
        edges(1);
    endtask

    task automatic test_cmd0;
        logic [15:0] v;
        load_msg(40'h40_0000_0000);
        bus_write(4'h4, 16'h0001);
        edges(40);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL cmd0_status got=%h exp=%h", v, 16'h0001); end
        bus_read(4'h8, v); total++;
        if (v !== 16'h004A) begin bad++; $display("FAIL cmd0_crc got=%h exp=%h", v, 16'h004A); end
        bus_read(4'hC, v); total++;
        if (v !== 16'h0095) begin bad++; $display("FAIL cmd0_sdcrc got=%h exp=%h", v, 16'h0095); end
    endtask

    task automatic test_cmd8;
        logic [15:0] v;
        load_msg(40'h48_0000_01AA);
        bus_write(4'h4, 16'h0001);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0002) begin bad++; $display("FAIL cmd8_started got=%h exp=%h", v, 16'h0002); end
        edges(39);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0002) begin bad++; $display("FAIL cmd8_at39 got=%h exp=%h", v, 16'h0002); end
        edges(1);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL cmd8_at40 got=%h exp=%h", v, 16'h0001); end
        bus_read(4'h8, v); total++;
        if (v !== 16'h0043) begin bad++; $display("FAIL cmd8_crc got=%h exp=%h", v, 16'h0043); end
        bus_read(4'hC, v); total++;
        if (v !== 16'h0087) begin bad++; $display("FAIL cmd8_sdcrc got=%h exp=%h", v, 16'h0087); end
        edges(5);
        bus_read(4'h8, v); total++;
        if (v !== 16'h0043) begin bad++; $display("FAIL cmd8_hold got=%h exp=%h", v, 16'h0043); end
    endtask

    task automatic test_busy_lockout;
        logic [15:0] v;
        load_msg(40'h40_0000_0000);
        bus_write(4'h4, 16'h0001);          // edge N
        edges(9);                            // edge N+9
        bus_write(4'h0, 16'h00FF);          // edge N+10
        bus_write(4'h4, 16'h0001);          // edge N+11
        edges(28);                           // edge N+39
        bus_read(4'h6, v); total++;
        if (v !== 16'h0002) begin bad++; $display("FAIL lock_at39 got=%h exp=%h", v, 16'h0002); end
        edges(1);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL lock_at40 got=%h exp=%h", v, 16'h0001); end
        bus_read(4'h8, v); total++;
        if (v !== 16'h004A) begin bad++; $display("FAIL lock_crc got=%h exp=%h", v, 16'h004A); end
        // rerun without reloading: the 0xFF write must not have reached msg
        bus_write(4'h4, 16'h0001);
        edges(40);
        bus_read(4'h8, v); total++;
        if (v !== 16'h004A) begin bad++; $display("FAIL lock_msg_kept got=%h exp=%h", v, 16'h004A); end
    endtask

    task automatic test_start_zero;
        logic [15:0] v;
        bus_write(4'h4, 16'h0000);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL start0_status got=%h exp=%h", v, 16'h0001); end
    endtask

    task automatic test_cs_gating;
        logic [15:0] v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b1; addr = 4'h4; d_in = 16'h0001;
        @(posedge clk);
        #1;
        wr = 1'b0; d_in = '0;
        rd = 1'b1; addr = 4'h6; #1;
        total++;
        if (d_out !== 16'h0000) begin bad++; $display("FAIL cs_off_read got=%h exp=%h", d_out, 16'h0000); end
        rd = 1'b0; addr = '0;
        bus_read(4'h6, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL cs_no_start got=%h exp=%h", v, 16'h0001); end
        bus_read(4'h3, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL unmapped got=%h exp=%h", v, 16'h0000); end
        cs = 1'b1; rd = 1'b0; addr = 4'h8; #1;
        total++;
        if (d_out !== 16'h0000) begin bad++; $display("FAIL no_rd got=%h exp=%h", d_out, 16'h0000); end
        cs = 1'b0; addr = '0;
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        load_msg(40'h48_0000_01AA);
        bus_write(4'h4, 16'h0001);
        edges(19);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL rstmid_status got=%h exp=%h", v, 16'h0000); end
        rst = 1'b1;
        edges(2);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL rstmid_after got=%h exp=%h", v, 16'h0000); end
        bus_read(4'h8, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL rstmid_crc got=%h exp=%h", v, 16'h0000); end
        load_msg(40'h40_0000_0000);
        bus_write(4'h4, 16'h0001);
        edges(40);
        bus_read(4'h8, v); total++;
        if (v !== 16'h004A) begin bad++; $display("FAIL rstmid_rerun got=%h exp=%h", v, 16'h004A); end
    endtask

    task automatic test_zero_msg;
        logic [15:0] v;
        load_msg(40'h0);
        bus_write(4'h4, 16'h0001);
        edges(40);
        bus_read(4'h6, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL zero_status got=%h exp=%h", v, 16'h0001); end
        bus_read(4'h8, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL zero_crc got=%h exp=%h", v, 16'h0000); end
        bus_read(4'hC, v); total++;
        if (v !== 16'h0001) begin bad++; $display("FAIL zero_sdcrc got=%h exp=%h", v, 16'h0001); end
    endtask

    initial begin
        test_reset;
        test_cmd0;
        test_cmd8;
        test_busy_lockout;
        test_start_zero;
        test_cs_gating;
        test_reset_mid;
        test_zero_msg;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
